fetch_prefetch_unit: RTL and testbench
======================================

# fetch_prefetch_unit

Parametrised instruction fetch front end with a DEPTH-entry prefetch buffer, replacing the fixed-step IFU/IFU_CONTROL pair between main memory and the decode unit. It issues one outstanding read at a time over a request/valid handshake, queues returned words with their PC, and presents them to decode with a valid/ready handshake. It also supports halt and single-cycle redirect (flush plus new PC) for branches.

## Interface
- XLEN, 32: instruction/address width.
- DEPTH, 4: prefetch buffer entries; power of two, ≥2.
- RESET_PC, 32'h00000000: fetch PC after reset.
- PC_STEP, 4: PC increment per returned word.
- clock_in  input  1  single clock; all state updates on rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- halt_in  input  1  blocks new memory requests; buffer keeps draining.
- redirect_in  input  1  flush buffer and load redirect_addr_in as fetch PC.
- redirect_addr_in  input  XLEN  new fetch PC; bits [1:0] forced to 0.
- mem_addr_out  output  XLEN  read address (= fetch PC).
- mem_read_out  output  1  read request, held until mem_valid_in.
- mem_valid_in  input  1  read data valid; completes the request.
- mem_data_in  input  XLEN  read data.
- ins_valid_out  output  1  head entry valid.
- ins_data_out  output  XLEN  head instruction word.
- ins_pc_out  output  XLEN  PC of head instruction.
- ins_ready_in  input  1  decode accepts head when ins_valid_out=1.
- count_out  output  $clog2(DEPTH)+1  occupied entries.

## Operation
- States: IDLE (no request), REQ (request outstanding), DROP (request outstanding, response to be discarded). mem_read_out = (state==REQ || state==DROP).
- Can-issue = !halt_in && count < DEPTH (registered count).
- IDLE → REQ when can-issue and !redirect_in. IDLE with redirect_in: load PC, stay IDLE.
- REQ, mem_valid_in=1, no redirect: write {mem_data_in, fetch PC} at tail; fetch PC += PC_STEP; next state REQ if !halt_in and post-write count < DEPTH, else IDLE.
- REQ, mem_valid_in=0: hold mem_addr_out, stay REQ (halt_in does not abort).
- Redirect: count → 0, head/tail → 0, fetch PC ← redirect_addr_in & ~3. From REQ without mem_valid_in → DROP; from REQ with mem_valid_in → data discarded, IDLE.
- DROP: mem_addr_out holds old address until mem_valid_in, data discarded, then IDLE. Redirect in DROP updates PC, stays DROP.
- Pop: ins_valid_out && ins_ready_in advances head. Push and pop in the same cycle leave count unchanged. Push only occurs when count < DEPTH, so overflow is impossible. Pop on empty is ignored.
- Pop in a redirect cycle counts as accepted by decode; the flush still clears everything.
- Pointers wrap modulo DEPTH.

## Timing
- Reset: state IDLE, fetch PC = RESET_PC, mem_read_out 0, ins_valid_out 0, ins_data_out 0, ins_pc_out 0, count_out 0, storage zeroed.
- First request: mem_read_out rises one cycle after reset release (halt_in=0).
- Baseline latency: mem_valid_in at edge N → ins_valid_out high in cycle after edge N.
- Zero-wait memory sustains one word per cycle while not full.
- Redirect takes effect at the edge it is sampled; ins_valid_out is 0 the following cycle.

## Configuration
- CORE101_FETCH_BYPASS_EN defined: when count==0 and a non-discarded response arrives in REQ, ins_valid_out/ins_data_out/ins_pc_out are driven combinationally from mem_data_in and fetch PC in the same cycle. If ins_ready_in=1, the word is consumed and not written. Otherwise it is written normally.
- Undefined: outputs come only from storage; one-cycle minimum latency.

## Structure
- core101_pkg: state encoding localparams (IDLE/REQ/DROP), default XLEN, RESET_PC, PC_STEP.
- Sub-module fetch_fifo: DEPTH×(2·XLEN) circular buffer with head/tail/count, push/pop/flush ports.
- FSM, PC register and bypass logic live in fetch_prefetch_unit.

## Test plan
- Reset, zero-wait memory, ins_ready_in=1: PCs 0x0,0x4,0x8… appear one per cycle, count_out ≤1.
- ins_ready_in=0, DEPTH=4: exactly 4 words queued (PCs 0x0–0xC), mem_read_out low, count_out=4. One pop → one new request at 0x10.
- Redirect to 0x103 while REQ waits (mem_valid_in delayed 3 cycles): stale word discarded, count_out=0, next request address 0x100, first valid ins_pc_out 0x100.
- halt_in=1 mid-request: outstanding word still written, no further mem_read_out until halt_in=0, buffer drains normally.
- reset_in low mid-REQ with 2 entries: all outputs return to reset values immediately. After release, fetch resumes at RESET_PC.
- With CORE101_FETCH_BYPASS_EN, empty buffer, ready=1: ins_valid_out high in same cycle as mem_valid_in, count_out stays 0.

Source files
------------

// File: rtl/core101_pkg.sv
// core101_pkg: shared fetch FSM state encoding and default front-end parameters.
package core101_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;
    localparam int          DEF_XLEN     = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          DEF_PC_STEP  = 4;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer of {instruction, pc} words with flush.
module fetch_fifo #(
    parameter int W = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic          do_push, do_pop;

    assign do_push   = push && count < CW'(DEPTH);
    assign do_pop    = pop && count != '0;
    assign head_data = mem[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[tail] <= push_data;
                tail      <= tail + AW'(1);
            end
            if (do_pop) head <= head + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: single-outstanding-read fetch front end with prefetch buffer and redirect.
// Define CORE101_FETCH_BYPASS_EN to forward a response straight to decode when the buffer is empty.
module fetch_prefetch_unit import core101_pkg::*; #(
    parameter int               XLEN     = DEF_XLEN,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEF_RESET_PC),
    parameter int               PC_STEP  = DEF_PC_STEP,
    localparam int              CW       = $clog2(DEPTH) + 1
) (
    input  logic            clock_in,
    input  logic            reset_in,
    input  logic            halt_in,
    input  logic            redirect_in,
    input  logic [XLEN-1:0] redirect_addr_in,
    output logic [XLEN-1:0] mem_addr_out,
    output logic            mem_read_out,
    input  logic            mem_valid_in,
    input  logic [XLEN-1:0] mem_data_in,
    output logic            ins_valid_out,
    output logic [XLEN-1:0] ins_data_out,
    output logic [XLEN-1:0] ins_pc_out,
    input  logic            ins_ready_in,
    output logic [CW-1:0]   count_out
);
    fetch_state_t      state;
    logic [XLEN-1:0]   pc, drop_addr;
    logic [CW-1:0]     count, next_count;
    logic [2*XLEN-1:0] head;
    logic              can_issue, resp, byp, push, pop;

    assign can_issue = !halt_in && count < CW'(DEPTH);
    assign resp      = state == REQ && mem_valid_in && !redirect_in;
`ifdef CORE101_FETCH_BYPASS_EN
    assign byp       = resp && count == '0;
`else
    assign byp       = 1'b0;
`endif
    assign push          = resp && !(byp && ins_ready_in);
    assign pop           = ins_ready_in && count != '0;
    assign next_count    = count + CW'(push) - CW'(pop);
    assign ins_valid_out = byp || count != '0;
    assign ins_data_out  = byp ? mem_data_in : head[2*XLEN-1:XLEN];
    assign ins_pc_out    = byp ? pc : head[XLEN-1:0];
    assign mem_read_out  = state != IDLE;
    // A dropped request keeps presenting its original address even after the PC moved
    assign mem_addr_out  = state == DROP ? drop_addr : pc;
    assign count_out     = count;

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            drop_addr <= '0;
        end else if (redirect_in) begin
            pc <= redirect_addr_in & ~XLEN'(3);
            if (state == REQ) begin
                state     <= mem_valid_in ? IDLE : DROP;
                drop_addr <= pc;
            end else if (state == DROP && mem_valid_in) begin
                state <= IDLE;
            end
        end else begin
            case (state)
                IDLE: if (can_issue) state <= REQ;
                REQ: if (mem_valid_in) begin
                    pc    <= pc + XLEN'(PC_STEP);
                    state <= (!halt_in && next_count < CW'(DEPTH)) ? REQ : IDLE;
                end
                DROP: if (mem_valid_in) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    fetch_fifo #(.W(2 * XLEN), .DEPTH(DEPTH)) u_fifo (
        .clk       (clock_in),
        .rst_n     (reset_in),
        .flush     (redirect_in),
        .push      (push),
        .push_data ({mem_data_in, pc}),
        .pop       (pop),
        .head_data (head),
        .count     (count)
    );
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed vector table, corner sequences and random traffic against a queue model.
module tb_fetch_prefetch_unit;
    localparam int DEPTH = 4;
`ifdef CORE101_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        clock_in = 0, reset_in = 0, halt_in = 0, redirect_in = 0, mem_valid_in = 0, ins_ready_in = 0;
    logic [31:0] redirect_addr_in = 0, mem_data_in = 0;
    logic [31:0] mem_addr_out, ins_data_out, ins_pc_out;
    logic        mem_read_out, ins_valid_out;
    logic [2:0]  count_out;
    int          tests = 0, fails = 0;

    typedef struct {logic [31:0] d; logic [31:0] p;} ent_t;
    ent_t        q[$];
    bit          m_pend, m_disc;
    logic [31:0] m_pc, m_paddr;

    typedef struct {
        bit h, r; logic [31:0] ra; bit mv; logic [31:0] md; bit rdy;
        bit e_read; logic [31:0] e_addr; bit e_valid; logic [31:0] e_pc, e_data; int e_cnt;
    } vec_t;
    vec_t tbl[15];

    fetch_prefetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clock_in(clock_in), .reset_in(reset_in), .halt_in(halt_in), .redirect_in(redirect_in),
        .redirect_addr_in(redirect_addr_in), .mem_addr_out(mem_addr_out), .mem_read_out(mem_read_out),
        .mem_valid_in(mem_valid_in), .mem_data_in(mem_data_in), .ins_valid_out(ins_valid_out),
        .ins_data_out(ins_data_out), .ins_pc_out(ins_pc_out), .ins_ready_in(ins_ready_in),
        .count_out(count_out)
    );

    always #5 clock_in = ~clock_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pend = 0; m_disc = 0; m_pc = 0; m_paddr = 0;
    endtask

    function automatic bit m_byp();
        return BYP && m_pend && !m_disc && mem_valid_in && !redirect_in && q.size() == 0;
    endfunction

    task automatic check_model();
        bit b = m_byp();
        int n = q.size();
        chk("mem_read", 32'(mem_read_out), 32'(m_pend));
        chk("mem_addr", mem_addr_out, m_pend ? m_paddr : m_pc);
        chk("ins_valid", 32'(ins_valid_out), 32'(n > 0 || b));
        chk("count", 32'(count_out), 32'(n));
        if (n > 0 || b) begin
            chk("ins_data", ins_data_out, n > 0 ? q[0].d : mem_data_in);
            chk("ins_pc", ins_pc_out, n > 0 ? q[0].p : m_pc);
        end
    endtask

    task automatic drive(input bit h, r, input logic [31:0] ra, input bit mv, input logic [31:0] md, input bit rdy);
        halt_in = h; redirect_in = r; redirect_addr_in = ra;
        mem_valid_in = mv; mem_data_in = md; ins_ready_in = rdy;
        @(negedge clock_in);
        check_model();
    endtask

    // Model update for the edge about to happen, from the inputs currently applied
    task automatic advance();
        int n0 = q.size();
        bit b = m_byp();
        if (redirect_in) begin
            q.delete();
            m_pc = redirect_addr_in & ~32'h3;
            if (m_pend) begin
                if (mem_valid_in) begin m_pend = 0; m_disc = 0; end
                else m_disc = 1;
            end
        end else begin
            if (ins_ready_in && n0 > 0) void'(q.pop_front());
            if (m_pend && mem_valid_in) begin
                if (m_disc) begin
                    m_pend = 0; m_disc = 0;
                end else begin
                    if (!(b && ins_ready_in)) q.push_back('{mem_data_in, m_pc});
                    m_pc += 4;
                    m_pend = !halt_in && q.size() < DEPTH;
                    m_paddr = m_pc;
                end
            end else if (!m_pend && !halt_in && n0 < DEPTH) begin
                m_pend = 1;
                m_paddr = m_pc;
            end
        end
        @(posedge clock_in);
        #1;
    endtask

    task automatic cyc(input bit h, r, input logic [31:0] ra, input bit mv, input logic [31:0] md, input bit rdy);
        drive(h, r, ra, mv, md, rdy);
        advance();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_mem_read"}, 32'(mem_read_out), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr_out, 32'h0);
        chk({tag, "_ins_valid"}, 32'(ins_valid_out), 32'd0);
        chk({tag, "_ins_data"}, ins_data_out, 32'h0);
        chk({tag, "_ins_pc"}, ins_pc_out, 32'h0);
        chk({tag, "_count"}, 32'(count_out), 32'd0);
    endtask

    initial begin
        tbl[0]  = '{0, 0, 32'h0,   0, 32'h0,         0, 0, 32'h00,  0,   32'h0,   32'h0,         0};
        tbl[1]  = '{0, 0, 32'h0,   1, 32'hA000_0000, 0, 1, 32'h00,  BYP, 32'h0,   32'hA000_0000, 0};
        tbl[2]  = '{0, 0, 32'h0,   1, 32'hA000_0001, 0, 1, 32'h04,  1,   32'h0,   32'hA000_0000, 1};
        tbl[3]  = '{0, 0, 32'h0,   1, 32'hA000_0002, 0, 1, 32'h08,  1,   32'h0,   32'hA000_0000, 2};
        tbl[4]  = '{0, 0, 32'h0,   1, 32'hA000_0003, 0, 1, 32'h0C,  1,   32'h0,   32'hA000_0000, 3};
        tbl[5]  = '{0, 0, 32'h0,   0, 32'h0,         0, 0, 32'h10,  1,   32'h0,   32'hA000_0000, 4};
        tbl[6]  = '{0, 0, 32'h0,   0, 32'h0,         1, 0, 32'h10,  1,   32'h0,   32'hA000_0000, 4};
        tbl[7]  = '{0, 0, 32'h0,   0, 32'h0,         0, 0, 32'h10,  1,   32'h4,   32'hA000_0001, 3};
        tbl[8]  = '{0, 1, 32'h103, 0, 32'h0,         0, 1, 32'h10,  1,   32'h4,   32'hA000_0001, 3};
        tbl[9]  = '{0, 0, 32'h0,   0, 32'h0,         0, 1, 32'h10,  0,   32'h0,   32'h0,         0};
        tbl[10] = '{0, 0, 32'h0,   1, 32'hDEAD_BEEF, 0, 1, 32'h10,  0,   32'h0,   32'h0,         0};
        tbl[11] = '{0, 0, 32'h0,   0, 32'h0,         0, 0, 32'h100, 0,   32'h0,   32'h0,         0};
        tbl[12] = '{0, 0, 32'h0,   1, 32'hB0,        0, 1, 32'h100, BYP, 32'h100, 32'hB0,        0};
        tbl[13] = '{0, 0, 32'h0,   0, 32'h0,         1, 1, 32'h104, 1,   32'h100, 32'hB0,        1};
        tbl[14] = '{0, 0, 32'h0,   0, 32'h0,         1, 1, 32'h104, 0,   32'h0,   32'h0,         0};

        model_reset();
        repeat (2) @(posedge clock_in);
        #1;
        check_reset_values("reset");
        reset_in = 1;

        foreach (tbl[i]) begin
            drive(tbl[i].h, tbl[i].r, tbl[i].ra, tbl[i].mv, tbl[i].md, tbl[i].rdy);
            chk($sformatf("tbl_read[%0d]", i), 32'(mem_read_out), 32'(tbl[i].e_read));
            chk($sformatf("tbl_addr[%0d]", i), mem_addr_out, tbl[i].e_addr);
            chk($sformatf("tbl_valid[%0d]", i), 32'(ins_valid_out), 32'(tbl[i].e_valid));
            chk($sformatf("tbl_count[%0d]", i), 32'(count_out), 32'(tbl[i].e_cnt));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl_pc[%0d]", i), ins_pc_out, tbl[i].e_pc);
                chk($sformatf("tbl_data[%0d]", i), ins_data_out, tbl[i].e_data);
            end
            advance();
        end

        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 0, m_pend, $urandom, 1);
            chk("zero_wait_count_le1", 32'(count_out <= 1), 32'd1);
            advance();
        end

        // Halt while a request is outstanding: it must still complete and land
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 32'hC0DE_0001, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, 1);
            chk("halt_no_read", 32'(mem_read_out), 32'd0);
            advance();
        end
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, m_pend, $urandom, 0);

        cyc(0, 1, 32'h200, 0, 0, 0);
        for (int i = 0; i < 20 && !(q.size() == 2 && m_pend && !m_disc); i++)
            cyc(0, 0, 0, m_pend, $urandom, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("pre_reset_count", 32'(count_out), 32'd2);
        chk("pre_reset_read", 32'(mem_read_out), 32'd1);
        reset_in = 0;
        #1;
        check_reset_values("async_reset");
        @(posedge clock_in);
        #1;
        reset_in = 1;
        model_reset();
        drive(0, 0, 0, 0, 0, 0);
        chk("post_reset_idle", 32'(mem_read_out), 32'd0);
        advance();
        drive(0, 0, 0, 0, 0, 0);
        chk("post_reset_req", 32'(mem_read_out), 32'd1);
        chk("post_reset_addr", mem_addr_out, 32'h0);
        advance();

        for (int i = 0; i < 800; i++) begin
            bit h = ($urandom % 8) == 0;
            bit r = ($urandom % 20) == 0;
            bit mv = m_pend && ($urandom % 3) != 0;
            bit rdy = ($urandom % 4) != 0;
            cyc(h, r, $urandom, mv, $urandom, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
